binary_to_ascii: RTL and testbench
==================================

BINARY_TO_ASCII -- requirements
Module: binary_to_ascii

Interface
REQ-001: Parameter BIN_WIDTH SHALL default to 13 and set the width of the unsigned binary input.
REQ-002: Parameter BCD_DIGITS SHALL default to 4 and set the number of decimal digits produced.
REQ-003: Port clk SHALL be input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004: Port reset SHALL be input, 1 bit: synchronous, active-high reset.
REQ-005: Port enable SHALL be input, 1 bit: global clock-enable for the converter.
REQ-006: Port start SHALL be input, 1 bit: level request to begin a conversion, sampled only in IDLE.
REQ-007: Port bin SHALL be input, BIN_WIDTH bits: unsigned value to convert.
REQ-008: Port ascii_out SHALL be output, BCD_DIGITS*8 bits, registered: ASCII decimal string, most significant digit in bits [BCD_DIGITS*8-1 -: 8].
REQ-009: Port ready SHALL be output, 1 bit, registered: one-cycle pulse marking a new valid ascii_out.

Function
REQ-010: The block SHALL implement a sequential shift-add-3 (double-dabble) converter with states IDLE and SHIFT.
REQ-011: In IDLE, an edge with enable=1 and start=1 SHALL latch bin into a shift register, clear the BCD accumulator to 0, load a bit counter with BIN_WIDTH, and enter SHIFT.
REQ-012: In IDLE, an edge with start=0 SHALL remain in IDLE.
REQ-013: In SHIFT, each enabled edge SHALL first add 3 to every BCD nibble whose value is 5 or more, then shift {BCD accumulator, shift register} left by one bit, and decrement the counter.
REQ-014: On the enabled edge performing the BIN_WIDTH-th shift, the block SHALL write ascii_out from the final BCD result, with each byte equal to 8'h30 plus its digit, assert ready for exactly the following cycle, and return to IDLE.
REQ-015: Latency SHALL be BIN_WIDTH+1 enabled edges from the start-sampling edge to the edge that raises ready.
REQ-016: If start is still high during the ready cycle, the next conversion SHALL launch on that edge, giving a back-to-back period of BIN_WIDTH+1 cycles.
REQ-017: Changes on bin after the latching edge SHALL NOT affect the conversion in progress.
REQ-018: start asserted while in SHIFT SHALL be ignored and SHALL NOT restart the conversion.
REQ-019: Leading zeros SHALL be emitted as ASCII '0' (8'h30); there SHALL be no blanking.
REQ-020: Parameters SHALL satisfy 2^BIN_WIDTH-1 < 10^BCD_DIGITS; otherwise digits above BCD_DIGITS are discarded, so the result is the value modulo 10^BCD_DIGITS.
REQ-021: When enable=0, FSM state, counter, shift registers and ascii_out SHALL hold, and ready SHALL be driven to 0 on that edge.
REQ-022: ascii_out SHALL hold its last value between conversions and change only on the completion edge.

Reset
REQ-023: reset=1 at an edge SHALL force IDLE, clear the counter and internal registers, set ready=0, and set every ascii_out byte to 8'h30 ("0000").
REQ-024: reset SHALL take priority over enable and start.
REQ-025: reset during SHIFT SHALL abort the conversion with no ready pulse.

Verification
REQ-026: After reset, with start held high and bin=76 -> ready pulses 14 cycles after the launch edge; ascii_out=32'h30303736 ("0076").
REQ-027: Back-to-back conversions, with start held high and bin updated on each ready pulse: 69, 255, 0, 4008 -> "0069", "0255", "0000", "4008", each 14 cycles apart.
REQ-028: Boundary and truncated input: bin=8191 -> "8191"; bin=13'd112604, which truncates to 6108 -> "6108".
REQ-029: Input stability: change bin from 100 to 9 mid-SHIFT -> result is "0100".
REQ-030: Control corner cases:
- enable=0 for 5 cycles mid-SHIFT -> completion is delayed by exactly 5 cycles and the result is correct.
- reset asserted mid-SHIFT -> no ready pulse; ascii_out="0000".

Source files
------------

// File: rtl/binary_to_ascii.sv
// ---------------------------------------------------------------------------
// binary_to_ascii
//   Sequential shift-add-3 (double-dabble) converter that turns an unsigned
//   binary value into a fixed-width ASCII decimal string. One bit is consumed
//   per enabled clock, so a conversion takes BIN_WIDTH+1 enabled edges from
//   the edge that samples start to the edge that raises ready.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high; wins over enable and start
//   enable     : clock-enable; when low everything holds and ready drops
//   start      : level request, sampled only while idle
//   bin        : unsigned input, captured on the launch edge
//   ascii_out  : registered ASCII digits, most significant digit in the top byte
//   ready      : registered one-cycle pulse marking a fresh ascii_out
// ---------------------------------------------------------------------------
module binary_to_ascii #(
  parameter int BIN_WIDTH  = 13,
  parameter int BCD_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin,
  output logic [BCD_DIGITS*8-1:0] ascii_out,
  output logic                    ready
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BCD_W = BCD_DIGITS * 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                  state_q,  state_d;
  logic [BIN_WIDTH-1:0]    shift_q,  shift_d;
  logic [BCD_W-1:0]        bcd_q,    bcd_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [BCD_DIGITS*8-1:0] ascii_q,  ascii_d;
  logic                    ready_q,  ready_d;

  // One double-dabble step, computed every cycle and used only in SHIFT.
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_shift;
  logic [BIN_WIDTH-1:0]    shift_shift;
  logic [BCD_DIGITS*8-1:0] ascii_next;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end

    // Carry out of the top nibble falls off, leaving the value modulo
    // 10^BCD_DIGITS when the parameters are undersized.
    {bcd_shift, shift_shift} = {bcd_adj, shift_q} << 1;

    ascii_next = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      ascii_next[i*8 +: 8] = 8'h30 + {4'h0, bcd_shift[i*4 +: 4]};
    end

    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ascii_d = ascii_q;
    ready_d = 1'b0;

    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shift_d = bin;
            bcd_d   = '0;
            cnt_d   = CNT_W'(BIN_WIDTH);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          bcd_d   = bcd_shift;
          shift_d = shift_shift;
          cnt_d   = cnt_q - CNT_W'(1);
          // cnt_q == 1 means this edge performs the last shift.
          if (cnt_q == CNT_W'(1)) begin
            ascii_d = ascii_next;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ascii_q <= {BCD_DIGITS{8'h30}};
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ascii_q <= ascii_d;
      ready_q <= ready_d;
    end
  end

  assign ascii_out = ascii_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_binary_to_ascii.sv
// ---------------------------------------------------------------------------
// tb_binary_to_ascii
//   Self-checking bench for binary_to_ascii with default parameters. Expected
//   strings come from a decimal reference (repeated /10 and %10 on the value
//   modulo 10^4); expected latency is BIN_WIDTH+1 enabled edges counted from
//   the launch edge, plus any disabled edges in between.
// ---------------------------------------------------------------------------
module tb_binary_to_ascii;

  localparam int BIN_WIDTH  = 13;
  localparam int BCD_DIGITS = 4;
  localparam int LAT        = BIN_WIDTH + 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable;
  logic                    start;
  logic [BIN_WIDTH-1:0]    bin;
  logic [BCD_DIGITS*8-1:0] ascii_out;
  logic                    ready;

  int checks   = 0;
  int failures = 0;

  binary_to_ascii #(
    .BIN_WIDTH (BIN_WIDTH),
    .BCD_DIGITS(BCD_DIGITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .bin      (bin),
    .ascii_out(ascii_out),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_ascii(input int unsigned v);
    logic [31:0]  s;
    int unsigned  m;
    m = v % 10000;
    s = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      s[i*8 +: 8] = 8'h30 + 8'(m % 10);
      m = m / 10;
    end
    return s;
  endfunction

  // Launch one conversion from idle and wait (bounded) for ready. Inputs are
  // driven and outputs sampled on falling edges. edges counts rising edges
  // from the launch edge up to the one that raised ready.
  task automatic run_conv(input logic [BIN_WIDTH-1:0] v, input int stall_at,
                          input int stall_len, input logic [BIN_WIDTH-1:0] v_late,
                          input bit rand_start, output int edges, output bit seen);
    bin    = v;
    start  = 1'b1;
    enable = 1'b1;
    edges  = 0;
    seen   = 1'b0;
    while (edges < 100 && !seen) begin
      @(negedge clk);
      edges++;
      if (ready) begin
        seen   = 1'b1;
        start  = 1'b0;
        enable = 1'b1;
      end else begin
        start  = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
        if (edges == 1) bin = v_late;
        enable = !(edges >= stall_at && edges < stall_at + stall_len);
      end
    end
    start  = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    bit bad_ready;
    reset = 1'b1; enable = 1'b1; start = 1'b1; bin = 13'd76;
    bad_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ready !== 1'b0) bad_ready = 1'b1;
    end
    enable = 1'b0;
    @(negedge clk);
    if (ready !== 1'b0) bad_ready = 1'b1;
    checks++;
    if (ascii_out !== 32'h30303030) begin
      failures++;
      $display("FAIL reset_ascii: got %h expected %h", ascii_out, 32'h30303030);
    end
    checks++;
    if (bad_ready) begin
      failures++;
      $display("FAIL reset_ready: ready went high while reset asserted, expected 0");
    end
    reset = 1'b0; enable = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || ascii_out !== 32'h30303030) begin
      failures++;
      $display("FAIL reset_idle: got ready=%b ascii=%h expected ready=0 ascii=30303030",
               ready, ascii_out);
    end
  endtask

  task automatic test_basic();
    int e; bit seen;
    run_conv(13'd76, 0, 0, 13'd76, 1'b0, e, seen);
    checks++;
    if (!seen || e != LAT) begin
      failures++;
      $display("FAIL basic_latency: got seen=%b edges=%0d expected edges=%0d", seen, e, LAT);
    end
    checks++;
    if (ascii_out !== 32'h30303736) begin
      failures++;
      $display("FAIL basic_value: got %h expected %h", ascii_out, 32'h30303736);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || ascii_out !== 32'h30303736) begin
      failures++;
      $display("FAIL basic_pulse: got ready=%b ascii=%h expected ready=0 ascii=30303736",
               ready, ascii_out);
    end
  endtask

  task automatic test_back_to_back();
    int vals [4] = '{69, 255, 0, 4008};
    int e; bit seen;
    bin = BIN_WIDTH'(vals[0]); start = 1'b1; enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = 0; seen = 1'b0;
      while (e < 100 && !seen) begin
        @(negedge clk);
        e++;
        if (ready) seen = 1'b1;
      end
      checks++;
      if (!seen || e != LAT) begin
        failures++;
        $display("FAIL b2b_period[%0d]: got seen=%b edges=%0d expected edges=%0d",
                 k, seen, e, LAT);
      end
      checks++;
      if (ascii_out !== ref_ascii(vals[k])) begin
        failures++;
        $display("FAIL b2b_value[%0d]: got %h expected %h", k, ascii_out, ref_ascii(vals[k]));
      end
      if (k < 3) bin = BIN_WIDTH'(vals[k+1]);
      else       start = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    int e; bit seen;
    int unsigned big;
    logic [BIN_WIDTH-1:0] t;
    run_conv(13'd8191, 0, 0, 13'd8191, 1'b0, e, seen);
    checks++;
    if (!seen || e != LAT || ascii_out !== 32'h38313931) begin
      failures++;
      $display("FAIL boundary_max: got seen=%b edges=%0d ascii=%h expected edges=%0d ascii=38313931",
               seen, e, ascii_out, LAT);
    end
    big = 112604;
    t   = BIN_WIDTH'(big);
    run_conv(t, 0, 0, t, 1'b0, e, seen);
    checks++;
    if (!seen || ascii_out !== ref_ascii(big % 8192) || ascii_out !== 32'h36313038) begin
      failures++;
      $display("FAIL boundary_trunc: got seen=%b ascii=%h expected ascii=36313038", seen, ascii_out);
    end
  endtask

  task automatic test_bin_stability();
    int e; bit seen;
    run_conv(13'd100, 0, 0, 13'd9, 1'b0, e, seen);
    checks++;
    if (!seen || e != LAT || ascii_out !== 32'h30313030) begin
      failures++;
      $display("FAIL bin_stability: got seen=%b edges=%0d ascii=%h expected edges=%0d ascii=30313030",
               seen, e, ascii_out, LAT);
    end
  endtask

  task automatic test_enable_stall();
    int e; bit seen;
    run_conv(13'd1234, 4, 5, 13'd1234, 1'b0, e, seen);
    checks++;
    if (!seen || e != LAT + 5) begin
      failures++;
      $display("FAIL stall_latency: got seen=%b edges=%0d expected edges=%0d", seen, e, LAT + 5);
    end
    checks++;
    if (ascii_out !== ref_ascii(1234)) begin
      failures++;
      $display("FAIL stall_value: got %h expected %h", ascii_out, ref_ascii(1234));
    end
  endtask

  task automatic test_hold_idle();
    logic [31:0] held;
    bit bad;
    held = ascii_out;
    bad  = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bin = BIN_WIDTH'($urandom_range(0, 8191));
      @(negedge clk);
      if (ready !== 1'b0 || ascii_out !== held) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL hold_idle: got ready=%b ascii=%h expected ready=0 ascii=%h",
               ready, ascii_out, held);
    end
  endtask

  task automatic test_reset_abort();
    int e; bit seen; bit pulsed;
    bin = 13'd4321; start = 1'b1; enable = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulsed = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ready !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin
      failures++;
      $display("FAIL abort_ready: ready pulsed after reset mid-conversion, expected none");
    end
    checks++;
    if (ascii_out !== 32'h30303030) begin
      failures++;
      $display("FAIL abort_ascii: got %h expected %h", ascii_out, 32'h30303030);
    end
    run_conv(13'd57, 0, 0, 13'd57, 1'b0, e, seen);
    checks++;
    if (!seen || e != LAT || ascii_out !== ref_ascii(57)) begin
      failures++;
      $display("FAIL abort_recover: got seen=%b edges=%0d ascii=%h expected edges=%0d ascii=%h",
               seen, e, ascii_out, LAT, ref_ascii(57));
    end
  endtask

  task automatic test_random();
    int e; bit seen;
    int stall_at, stall_len;
    logic [BIN_WIDTH-1:0] v, v_late;
    for (int n = 0; n < 25; n++) begin
      v      = BIN_WIDTH'($urandom_range(0, 8191));
      v_late = BIN_WIDTH'($urandom_range(0, 8191));
      if ($urandom_range(0, 1) == 1) begin
        stall_at  = int'($urandom_range(1, 12));
        stall_len = int'($urandom_range(1, 4));
      end else begin
        stall_at  = 0;
        stall_len = 0;
      end
      run_conv(v, stall_at, stall_len, v_late, 1'b1, e, seen);
      checks++;
      if (!seen || e != LAT + stall_len) begin
        failures++;
        $display("FAIL rand_latency[%0d]: got seen=%b edges=%0d expected edges=%0d",
                 n, seen, e, LAT + stall_len);
      end
      checks++;
      if (ascii_out !== ref_ascii(int'(v))) begin
        failures++;
        $display("FAIL rand_value[%0d]: bin=%0d got %h expected %h",
                 n, v, ascii_out, ref_ascii(int'(v)));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; bin = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundary();
    test_bin_stability();
    test_enable_stall();
    test_hold_idle();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
